hd_responder: RTL and testbench

- Disk-side responder for the processor's HD port. Serves single-word writes and multi-word burst reads from an internal word-addressed store organised as track/sector.
- A read burst supplies the word stream that the datapath consumes as HD read data, either loading registers or filling instruction RAM during program load. A write stores one processor register word.
- Models a seek latency on track change, with a valid/ready handshake on both the request and response sides.

---
 rtl/hd_pkg.sv | 27 ++
 rtl/hd_if.sv | 30 +++
 rtl/hd_storage.sv | 29 ++
 rtl/hd_responder.sv | 174 +++++++++++++++++
 tb/tb_hd_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/hd_pkg.sv
// Shared constants, FSM state encoding and address helpers for the HD port responder.
package hd_pkg;

  localparam int DATA_W     = 32;
  localparam int TRACK_W    = 5;
  localparam int SECTOR_W   = 6;
  localparam int LEN_W      = 8;
  localparam int SEEK_LAT   = 4;
  localparam int SWITCH_LAT = 1;

  localparam int ADDR_W = TRACK_W + SECTOR_W;
  localparam int CNT_W  = LEN_W + 1;
  localparam int LAT_W  = $clog2(SEEK_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    WR,
    XFER_RD,
    TSW
  } hd_state_e;

  function automatic logic [TRACK_W-1:0] track_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:SECTOR_W];
  endfunction

endpackage

// File: rtl/hd_if.sv
// Request/response bundle between the processor HD port (master) and the disk responder (slave).
interface hd_if;
  import hd_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [TRACK_W-1:0]  req_track;
  logic [SECTOR_W-1:0] req_sector;
  logic [LEN_W-1:0]    req_len;
  logic [DATA_W-1:0]   req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_last;
  logic                wr_done;
  logic                busy;
  logic                err;

  modport master (
    output req_valid, req_write, req_track, req_sector, req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last, wr_done, busy, err
  );

  modport slave (
    input  req_valid, req_write, req_track, req_sector, req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last, wr_done, busy, err
  );

endinterface

// File: rtl/hd_storage.sv
// Word store for the disk image: one write port, one registered read port, contents never reset.
module hd_storage
  import hd_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // The read register only moves on re, so it doubles as the held response word during stalls.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hd_responder.sv
// Disk-side responder: single-word writes and burst reads with seek and track-switch latency.
module hd_responder
  import hd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  hd_if.slave  bus
);

  hd_state_e          state_q, state_d;
  logic [TRACK_W-1:0] head_track_q, head_track_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   iss_cnt_q, iss_cnt_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               is_wr_q, is_wr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_last_q, rsp_last_d;
  logic               wr_done_q, wr_done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               req_ready_q, req_ready_d;
  logic               rd_en;
  logic               issue;
  logic               out_free;
  logic [DATA_W-1:0]  rd_data;

  hd_storage u_storage (
    .clk   (clk),
    .we    (state_q == WR),
    .waddr (addr_q),
    .wdata (wdata_q),
    .re    (rd_en),
    .raddr (addr_q),
    .rdata (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    head_track_d = head_track_q;
    addr_d       = addr_q;
    iss_cnt_d    = iss_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    wdata_d      = wdata_q;
    is_wr_d      = is_wr_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_last_d   = rsp_last_q;
    err_d        = 1'b0;
    rd_en        = 1'b0;
    issue        = 1'b0;
    out_free     = !rsp_valid_q || bus.rsp_ready;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (!bus.req_write && bus.req_len == '0) begin
            err_d = 1'b1;
          end else begin
            addr_d    = {bus.req_track, bus.req_sector};
            iss_cnt_d = {1'b0, bus.req_len};
            wdata_d   = bus.req_wdata;
            is_wr_d   = bus.req_write;
            if (bus.req_track != head_track_q) begin
              state_d   = SEEK;
              lat_cnt_d = LAT_W'(SEEK_LAT - 1);
            end else begin
              state_d = bus.req_write ? WR : XFER_RD;
            end
          end
        end
      end
      SEEK: begin
        if (lat_cnt_q == '0) begin
          head_track_d = track_of(addr_q);
          state_d      = is_wr_q ? WR : XFER_RD;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      WR: begin
        state_d = IDLE;
      end
      XFER_RD: begin
        // A word address on a track other than the head means the burst crossed a track boundary.
        if (out_free) begin
          if (rsp_valid_q && rsp_last_q) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
          end else if (iss_cnt_q != '0) begin
            if (track_of(addr_q) != head_track_q) begin
              state_d     = TSW;
              lat_cnt_d   = LAT_W'(SWITCH_LAT - 1);
              rsp_valid_d = 1'b0;
              rsp_last_d  = 1'b0;
            end else begin
              issue = 1'b1;
            end
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
          end
        end
      end
      TSW: begin
        // Fetch the first word of the new track on the last gap cycle so the gap is exactly SWITCH_LAT.
        if (lat_cnt_q == '0) begin
          head_track_d = head_track_q + 1'b1;
          state_d      = XFER_RD;
          issue        = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      rd_en       = 1'b1;
      addr_d      = addr_q + 1'b1;
      iss_cnt_d   = iss_cnt_q - 1'b1;
      rsp_valid_d = 1'b1;
      rsp_last_d  = (iss_cnt_q == CNT_W'(1));
    end

    busy_d      = (state_d != IDLE);
    req_ready_d = (state_d == IDLE);
    wr_done_d   = (state_d == WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      head_track_q <= '0;
      addr_q       <= '0;
      iss_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      wdata_q      <= '0;
      is_wr_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_last_q   <= 1'b0;
      wr_done_q    <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      head_track_q <= head_track_d;
      addr_q       <= addr_d;
      iss_cnt_q    <= iss_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      wdata_q      <= wdata_d;
      is_wr_q      <= is_wr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_last_q   <= rsp_last_d;
      wr_done_q    <= wr_done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      req_ready_q  <= req_ready_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_valid_q ? rd_data : '0;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_hd_responder.sv
// Directed bench for hd_responder: writes, seek/burst reads, stalls, track switch, wrap, reject, reset.
module tb_hd_responder;
  import hd_pkg::*;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [DATA_W-1:0] gotData[$];
  bit                gotLast[$];
  int                gotCycle[$];

  hd_if bus ();

  hd_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DATA_W-1:0] expWord(input int t, input int s);
    if (t == 0 && s == 5) return 32'hDEADBEEF;
    return 32'hC0DE_0000 | DATA_W'((t << 8) | s);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input bit wr, input int t, input int s,
                               input int len, input logic [DATA_W-1:0] wd);
    bus.req_valid  = valid;
    bus.req_write  = wr;
    bus.req_track  = TRACK_W'(t);
    bus.req_sector = SECTOR_W'(s);
    bus.req_len    = LEN_W'(len);
    bus.req_wdata  = wd;
  endtask

  task automatic sendReq(input bit wr, input int t, input int s, input int len, input logic [DATA_W-1:0] wd);
    bit acc = 1'b0;
    applyStimulus(1'b1, wr, t, s, len, wd);
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = bus.req_ready;
      step();
    end
    applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
    checkOutput("req_accept", acc, 1'b1);
  endtask

  task automatic writeWord(input int t, input int s, input logic [DATA_W-1:0] wd, output int doneCyc);
    int cyc = 0;
    sendReq(1'b1, t, s, 0, wd);
    while (!bus.wr_done && cyc < 50) begin
      step();
      cyc++;
    end
    doneCyc = cyc;
    step();
    checkOutput("wr_done_pulse", bus.wr_done, 1'b0);
    checkOutput("wr_back_idle", bus.req_ready, 1'b1);
  endtask

  task automatic collectWords(input int n, input bit toggle, input int budget);
    int cyc = 0;
    int k = 0;
    bit stalled = 1'b0;
    logic [DATA_W-1:0] held = '0;
    gotData.delete();
    gotLast.delete();
    gotCycle.delete();
    while (gotData.size() < n && cyc < budget) begin
      if (stalled) begin
        checkOutput("stall_valid", bus.rsp_valid, 1'b1);
        checkOutput("stall_data", bus.rsp_data, held);
      end
      if (bus.rsp_valid) begin
        bus.rsp_ready = toggle ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
        k++;
        if (bus.rsp_ready) begin
          gotData.push_back(bus.rsp_data);
          gotLast.push_back(bus.rsp_last);
          gotCycle.push_back(cyc);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = bus.rsp_data;
        end
      end else begin
        bus.rsp_ready = !toggle;
        stalled       = 1'b0;
      end
      step();
      cyc++;
    end
    bus.rsp_ready = 1'b1;
    checkOutput("burst_words", gotData.size(), n);
  endtask

  // Expected word i lives at linear address start+i; one SWITCH_LAT gap precedes every sector-0 word after the first.
  task automatic verifyBurst(input string tag, input int t0, input int s0, input int len, input int firstCyc);
    int expCyc = firstCyc;
    for (int i = 0; i < gotData.size(); i++) begin
      int a;
      int t;
      int s;
      a = ((t0 << SECTOR_W) + s0 + i) % (1 << ADDR_W);
      t = a >> SECTOR_W;
      s = a % (1 << SECTOR_W);
      if (i > 0 && s == 0) expCyc += SWITCH_LAT;
      checkOutput($sformatf("%s_data%0d", tag, i), gotData[i], expWord(t, s));
      checkOutput($sformatf("%s_last%0d", tag, i), gotLast[i], (i == len - 1));
      if (firstCyc >= 0) checkOutput($sformatf("%s_cyc%0d", tag, i), gotCycle[i], expCyc);
      expCyc++;
    end
  endtask

  initial begin
    int doneCyc;
    int preT[7] = '{3, 3, 3, 2, 2, 31, 0};
    int preS[7] = '{1, 2, 3, 62, 63, 63, 0};

    rst_n = 1'b0;
    bus.rsp_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0, 0, '0);
    repeat (2) step();
    $display("[TB] reset state");
    checkOutput("rst_req_ready", bus.req_ready, 1'b1);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("rst_rsp_last", bus.rsp_last, 1'b0);
    checkOutput("rst_rsp_data", bus.rsp_data, '0);
    checkOutput("rst_wr_done", bus.wr_done, 1'b0);
    checkOutput("rst_err", bus.err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step();

    $display("[TB] writes and preload");
    writeWord(0, 5, 32'hDEADBEEF, doneCyc);
    checkOutput("wr_lat_noseek", doneCyc, 0);
    writeWord(3, 0, expWord(3, 0), doneCyc);
    checkOutput("wr_lat_seek", doneCyc, SEEK_LAT);
    for (int i = 0; i < 7; i++) begin
      writeWord(preT[i], preS[i], expWord(preT[i], preS[i]), doneCyc);
    end

    $display("[TB] single word read back");
    sendReq(1'b0, 0, 5, 1, '0);
    collectWords(1, 1'b0, 50);
    verifyBurst("rd05", 0, 5, 1, 1);

    $display("[TB] seek burst, full rate");
    sendReq(1'b0, 3, 0, 4, '0);
    checkOutput("burst_busy", bus.busy, 1'b1);
    checkOutput("burst_req_ready", bus.req_ready, 1'b0);
    collectWords(4, 1'b0, 100);
    verifyBurst("rd30", 3, 0, 4, SEEK_LAT + 1);
    checkOutput("post_burst_ready", bus.req_ready, 1'b1);
    checkOutput("post_burst_busy", bus.busy, 1'b0);

    $display("[TB] burst with stalls");
    sendReq(1'b0, 3, 0, 4, '0);
    collectWords(4, 1'b1, 100);
    verifyBurst("stall", 3, 0, 4, -1);

    $display("[TB] track switch");
    sendReq(1'b0, 2, 62, 4, '0);
    collectWords(4, 1'b0, 100);
    verifyBurst("tsw", 2, 62, 4, SEEK_LAT + 1);
    sendReq(1'b0, 3, 2, 1, '0);
    collectWords(1, 1'b0, 50);
    verifyBurst("head3", 3, 2, 1, 1);

    $display("[TB] address wrap");
    sendReq(1'b0, 31, 63, 2, '0);
    collectWords(2, 1'b0, 100);
    verifyBurst("wrap", 31, 63, 2, SEEK_LAT + 1);

    $display("[TB] zero length reject");
    sendReq(1'b0, 5, 5, 0, '0);
    checkOutput("rej_err", bus.err, 1'b1);
    checkOutput("rej_busy", bus.busy, 1'b0);
    checkOutput("rej_ready", bus.req_ready, 1'b1);
    step();
    checkOutput("rej_err_pulse", bus.err, 1'b0);
    sendReq(1'b0, 0, 5, 1, '0);
    collectWords(1, 1'b0, 50);
    verifyBurst("head0", 0, 5, 1, 1);

    $display("[TB] reset mid burst");
    sendReq(1'b0, 3, 0, 4, '0);
    collectWords(2, 1'b0, 100);
    verifyBurst("abort", 3, 0, 4, SEEK_LAT + 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", bus.rsp_valid, 1'b0);
    checkOutput("abort_busy", bus.busy, 1'b0);
    checkOutput("abort_ready", bus.req_ready, 1'b1);
    #2 rst_n = 1'b1;
    step();
    checkOutput("abort_no_rsp", bus.rsp_valid, 1'b0);
    sendReq(1'b0, 3, 0, 4, '0);
    collectWords(4, 1'b0, 100);
    verifyBurst("intact", 3, 0, 4, SEEK_LAT + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
